// File: rtl/pwm_pkg.sv
// Shared helpers for the LED PWM fade bank: channel-index width and the
// saturating ramp step applied to each channel's duty at the period wrap.
package pwm_pkg;

    localparam int RAMP_W = 32;

    function automatic int chan_idx_w(input int channels);
        return (channels > 1) ? $clog2(channels) : 1;
    endfunction

    // One bit of headroom keeps duty+step and duty-step from wrapping.
    function automatic logic [RAMP_W-1:0] ramp_next(
        input logic [RAMP_W-1:0] duty,
        input logic [RAMP_W-1:0] target,
        input logic [RAMP_W-1:0] step
    );
        logic [RAMP_W:0]   sum;
        logic [RAMP_W:0]   diff;
        logic [RAMP_W-1:0] result;
        sum    = {1'b0, duty} + {1'b0, step};
        diff   = {1'b0, duty} - {1'b0, step};
        result = duty;
        if (step == '0) begin
            result = target;
        end else if (duty < target) begin
            result = (sum > {1'b0, target}) ? target : sum[RAMP_W-1:0];
        end else if (duty > target) begin
            result = (diff[RAMP_W] || (diff[RAMP_W-1:0] < target)) ? target : diff[RAMP_W-1:0];
        end
        return result;
    endfunction

endpackage

// File: rtl/pwm_fade_chan.sv
// One fading PWM channel: holds target/step/duty, ramps duty at each period
// wrap and compares the shared counter against the live duty.
module pwm_fade_chan
    import pwm_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             wr_en_i,
    input  logic             wrap_i,
    input  logic [WIDTH-1:0] cnt_i,
    input  logic [WIDTH-1:0] cfg_target_i,
    input  logic [WIDTH-1:0] cfg_step_i,
    output logic             pwm_o,
    output logic             busy_o
);

    logic [WIDTH-1:0] target_q;
    logic [WIDTH-1:0] step_q;
    logic [WIDTH-1:0] duty_q;
    logic [WIDTH-1:0] duty_d;
    logic             pwm_q;

    always_comb begin
        duty_d = duty_q;
        if (wrap_i) begin
            duty_d = WIDTH'(ramp_next(RAMP_W'(duty_q), RAMP_W'(target_q), RAMP_W'(step_q)));
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            target_q <= '0;
            step_q   <= '0;
            duty_q   <= '0;
            pwm_q    <= 1'b0;
        end else begin
            if (wr_en_i) begin
                target_q <= cfg_target_i;
                step_q   <= cfg_step_i;
            end
            duty_q <= duty_d;
            pwm_q  <= (cnt_i < duty_q);
        end
    end

    assign pwm_o  = pwm_q;
    assign busy_o = (duty_q != target_q);

endmodule

// File: rtl/pwm_fade_bank.sv
// Multi-channel fading PWM bank: shared prescaler and period counter, config
// handshake, one pwm_fade_chan per output.
module pwm_fade_bank
    import pwm_pkg::*;
#(
    parameter  int CHANNELS   = 4,
    parameter  int WIDTH      = 8,
    parameter  int PRESC_W    = 8,
    localparam int CHAN_IDX_W = chan_idx_w(CHANNELS)
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic [PRESC_W-1:0]    prescale_i,
    input  logic                  cfg_valid_i,
    output logic                  cfg_ready_o,
    input  logic [CHAN_IDX_W-1:0] cfg_chan_i,
    input  logic [WIDTH-1:0]      cfg_target_i,
    input  logic [WIDTH-1:0]      cfg_step_i,
    output logic [CHANNELS-1:0]   pwm_o,
    output logic [CHANNELS-1:0]   busy_o,
    output logic                  period_o
);

    logic [PRESC_W-1:0] pre_cnt_q;
    logic [PRESC_W-1:0] pre_cnt_d;
    logic [WIDTH-1:0]   cnt_q;
    logic [WIDTH-1:0]   cnt_d;
    logic               tick;
    logic               wrap;
    logic               accept;

    // >= rather than == so shrinking prescale_i mid-count ticks immediately.
    assign tick = (pre_cnt_q >= prescale_i);
    assign wrap = tick && (cnt_q == '1);

    always_comb begin
        pre_cnt_d = pre_cnt_q + PRESC_W'(1);
        cnt_d     = cnt_q;
        if (tick) begin
            pre_cnt_d = '0;
            cnt_d     = cnt_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            pre_cnt_q <= '0;
            cnt_q     <= '0;
        end else begin
            pre_cnt_q <= pre_cnt_d;
            cnt_q     <= cnt_d;
        end
    end

    // Writes are refused on the wrap clock so a duty update never races a config change.
    assign cfg_ready_o = rst_n_i && !wrap;
    assign period_o    = wrap;
    assign accept      = cfg_valid_i && cfg_ready_o;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
        pwm_fade_chan #(
            .WIDTH (WIDTH)
        ) u_chan (
            .clk_i        (clk_i),
            .rst_n_i      (rst_n_i),
            .wr_en_i      (accept && (cfg_chan_i == CHAN_IDX_W'(c))),
            .wrap_i       (wrap),
            .cnt_i        (cnt_q),
            .cfg_target_i (cfg_target_i),
            .cfg_step_i   (cfg_step_i),
            .pwm_o        (pwm_o[c]),
            .busy_o       (busy_o[c])
        );
    end

endmodule

// File: tb/tb_pwm_fade_bank.sv
// Directed bench for pwm_fade_bank: duty measured as high clocks per period.
module tb_pwm_fade_bank;

    logic       clk_i = 1'b0;
    logic       rst_n_i;
    logic [7:0] prescale_i;
    logic       cfg_valid_i;
    logic       cfg_ready_o;
    logic [1:0] cfg_chan_i;
    logic [7:0] cfg_target_i;
    logic [7:0] cfg_step_i;
    logic [3:0] pwm_o;
    logic [3:0] busy_o;
    logic       period_o;

    // three-channel instance exposes an out-of-range channel index
    logic       v3;
    logic       ready3;
    logic [1:0] chan3;
    logic [7:0] tgt3;
    logic [7:0] stp3;
    logic [2:0] pwm3;
    logic [2:0] busy3;
    logic       period3;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk_i = ~clk_i;

    pwm_fade_bank #(.CHANNELS(4), .WIDTH(8), .PRESC_W(8)) u_dut (
        .clk_i        (clk_i),
        .rst_n_i      (rst_n_i),
        .prescale_i   (prescale_i),
        .cfg_valid_i  (cfg_valid_i),
        .cfg_ready_o  (cfg_ready_o),
        .cfg_chan_i   (cfg_chan_i),
        .cfg_target_i (cfg_target_i),
        .cfg_step_i   (cfg_step_i),
        .pwm_o        (pwm_o),
        .busy_o       (busy_o),
        .period_o     (period_o)
    );

    pwm_fade_bank #(.CHANNELS(3), .WIDTH(8), .PRESC_W(8)) u_dut3 (
        .clk_i        (clk_i),
        .rst_n_i      (rst_n_i),
        .prescale_i   (prescale_i),
        .cfg_valid_i  (v3),
        .cfg_ready_o  (ready3),
        .cfg_chan_i   (chan3),
        .cfg_target_i (tgt3),
        .cfg_step_i   (stp3),
        .pwm_o        (pwm3),
        .busy_o       (busy3),
        .period_o     (period3)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Returns at the negedge just after a wrap edge (counter at 0).
    task automatic sync_wrap(input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 1200 && !seen; i++) begin
            @(negedge clk_i);
            if (period_o) seen = 1'b1;
        end
        check({tag, "_sync"}, 32'(seen), 1);
        @(negedge clk_i);
    endtask

    // Measures one full period from a post-wrap negedge; optional write at clk 1.
    task automatic run_period(input bit do_wr, input logic [1:0] ch, input logic [7:0] tgt,
                              input logic [7:0] stp, input int e0, input int e1,
                              input int e2, input int e3, input string tag);
        int hi[4];
        int np;
        int pk;
        hi = '{0, 0, 0, 0};
        np = 0;
        pk = 0;
        for (int k = 1; k <= 256; k++) begin
            @(negedge clk_i);
            for (int c = 0; c < 4; c++) hi[c] += int'(pwm_o[c]);
            if (period_o) begin
                np++;
                pk = k;
            end
            if (do_wr && k == 1) begin
                cfg_chan_i   = ch;
                cfg_target_i = tgt;
                cfg_step_i   = stp;
                cfg_valid_i  = 1'b1;
            end
            if (k == 2) cfg_valid_i = 1'b0;
        end
        check({tag, "_ch0"}, hi[0], e0);
        check({tag, "_ch1"}, hi[1], e1);
        check({tag, "_ch2"}, hi[2], e2);
        check({tag, "_ch3"}, hi[3], e3);
        check({tag, "_npulse"}, np, 1);
        check({tag, "_pulse_pos"}, pk, 255);
    endtask

    task automatic cfg_write(input logic [1:0] ch, input logic [7:0] tgt, input logic [7:0] stp);
        bit acc;
        acc = 1'b0;
        cfg_chan_i   = ch;
        cfg_target_i = tgt;
        cfg_step_i   = stp;
        cfg_valid_i  = 1'b1;
        for (int i = 0; i < 8 && !acc; i++) begin
            acc = cfg_ready_o;
            @(negedge clk_i);
        end
        cfg_valid_i = 1'b0;
        check("cfg_write_accept", 32'(acc), 1);
    endtask

    initial begin
        bit seen;
        int gap;
        int hi3;

        rst_n_i      = 1'b0;
        prescale_i   = 8'd0;
        cfg_valid_i  = 1'b0;
        cfg_chan_i   = 2'd0;
        cfg_target_i = 8'd0;
        cfg_step_i   = 8'd0;
        v3   = 1'b0;
        chan3 = 2'd0;
        tgt3 = 8'd0;
        stp3 = 8'd0;

        repeat (3) @(negedge clk_i);
        check("rst_pwm", pwm_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_ready", cfg_ready_o, 0);
        check("rst_period", period_o, 0);
        check("rst_pwm3", pwm3, 0);
        rst_n_i = 1'b1;
        #1;
        check("rel_ready", cfg_ready_o, 1);

        // jump ch0 to 128, then ramp ch1 up and ch2 down
        sync_wrap("start");
        run_period(1'b1, 2'd0, 8'd128, 8'd0,   0,   0,   0, 0, "p1");
        check("p1_busy", busy_o, 4'b0000);
        run_period(1'b1, 2'd1, 8'd200, 8'd64, 128,   0,   0, 0, "p2");
        check("p2_busy", busy_o, 4'b0010);
        run_period(1'b1, 2'd2, 8'd250, 8'd0,  128,  64,   0, 0, "p3");
        check("p3_busy", busy_o, 4'b0010);
        run_period(1'b1, 2'd2, 8'd10,  8'd100, 128, 128, 250, 0, "p4");
        check("p4_busy", busy_o, 4'b0110);
        run_period(1'b0, 2'd0, 8'd0,   8'd0,  128, 192, 150, 0, "p5");
        check("p5_busy", busy_o, 4'b0100);
        run_period(1'b0, 2'd0, 8'd0,   8'd0,  128, 200,  50, 0, "p6");
        check("p6_busy", busy_o, 4'b0000);
        run_period(1'b0, 2'd0, 8'd0,   8'd0,  128, 200,  10, 0, "p7");
        check("p7_busy", busy_o, 4'b0000);

        // request raised on the wrap clock is held off one clock
        seen = 1'b0;
        for (int i = 0; i < 600 && !seen; i++) begin
            @(negedge clk_i);
            if (period_o) seen = 1'b1;
        end
        check("hs_sync", 32'(seen), 1);
        check("hs_ready_on_wrap", cfg_ready_o, 0);
        cfg_chan_i   = 2'd3;
        cfg_target_i = 8'd1;
        cfg_step_i   = 8'd0;
        cfg_valid_i  = 1'b1;
        @(negedge clk_i);
        check("hs_ready_after", cfg_ready_o, 1);
        check("hs_not_yet", busy_o[3], 0);
        @(negedge clk_i);
        check("hs_landed", busy_o[3], 1);
        cfg_valid_i = 1'b0;

        v3    = 1'b1;
        chan3 = 2'd3;
        tgt3  = 8'd99;
        stp3  = 8'd0;
        @(negedge clk_i);
        check("oor_discard", busy3, 3'b000);
        chan3 = 2'd2;
        tgt3  = 8'd5;
        @(negedge clk_i);
        v3 = 1'b0;
        check("oor_valid_ch", busy3, 3'b100);

        sync_wrap("hs");
        run_period(1'b0, 2'd0, 8'd0, 8'd0, 128, 200, 10, 1, "p8");

        // prescale 3: wrap every 1024 clocks, counter holds 0 for 4 clocks
        prescale_i = 8'd3;
        seen = 1'b0;
        for (int i = 0; i < 1100 && !seen; i++) begin
            @(negedge clk_i);
            if (period_o) seen = 1'b1;
        end
        check("ps3_sync", 32'(seen), 1);
        gap  = 0;
        hi3  = 0;
        seen = 1'b0;
        for (int i = 0; i < 2100 && !seen; i++) begin
            @(negedge clk_i);
            gap++;
            hi3 += int'(pwm_o[3]);
            if (period_o) seen = 1'b1;
        end
        check("ps3_interval", gap, 1024);
        check("ps3_ch3_high", hi3, 4);
        @(negedge clk_i);
        check("ps3_pulse_width", period_o, 0);

        prescale_i = 8'd200;
        repeat (50) @(negedge clk_i);
        check("ps200_hold", pwm_o[3], 1);
        prescale_i = 8'd2;
        @(negedge clk_i);
        check("shrink_first", pwm_o[3], 1);
        @(negedge clk_i);
        check("shrink_tick", pwm_o[3], 0);

        // async reset in the middle of a ramp
        prescale_i = 8'd0;
        cfg_write(2'd0, 8'd250, 8'd10);
        sync_wrap("rr");
        check("rr_busy0", busy_o[0], 1);
        repeat (5) @(negedge clk_i);
        check("rr_pwm0", pwm_o[0], 1);
        #2;
        rst_n_i = 1'b0;
        #1;
        check("arst_pwm", pwm_o, 0);
        check("arst_busy", busy_o, 0);
        check("arst_ready", cfg_ready_o, 0);
        check("arst_pwm3", pwm3, 0);
        @(negedge clk_i);
        @(negedge clk_i);
        rst_n_i = 1'b1;
        #1;
        check("arst_rel_ready", cfg_ready_o, 1);
        check("arst_rel_busy", busy_o, 0);
        sync_wrap("post");
        run_period(1'b0, 2'd0, 8'd0, 8'd0, 0, 0, 0, 0, "p9");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
